// File: rtl/memory_stage_pkg.sv
// Shared pipeline definitions: access-size encodings and the MEM/WB bundle.
package memory_stage_pkg;

   localparam logic [1:0] SIZE_WORD = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_BYTE = 2'b10;

   typedef struct packed {
      logic        reg_write;
      logic        mem_to_reg;
      logic [31:0] alu_out;
      logic [31:0] read_data;
      logic [4:0]  write_reg;
      logic        misalign;
   } mem_wb_t;

endpackage

// File: rtl/data_memory.sv
// Word-organised data RAM with per-byte write enables and async read.
module data_memory #(
   parameter int DEPTH = 256,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [3:0]    i_be,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH];

   // contents are deliberately left unreset
   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int i = 0; i < 4; i++) begin
            if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
         end
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/memory_stage.sv
// MEM stage: alignment check, store lane steering, load extension, MEM/WB reg.
module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteM,
   input  logic        MemToRegM,
   input  logic        MemWriteM,
   input  logic [1:0]  MemSizeM,
   input  logic        MemSignedM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   input  logic [4:0]  WriteRegM,
   input  logic        StallW,
   input  logic        FlushW,
   output logic        RegWriteW,
   output logic        MemToRegW,
   output logic [31:0] ALUOutW,
   output logic [31:0] ReadDataW,
   output logic [4:0]  WriteRegW,
   output logic        MisalignW
);

   localparam int AW = $clog2(DEPTH);

   logic        w_misalign;
   logic        w_we;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_rword;
   logic [31:0] w_load;
   logic [15:0] w_half;
   logic [7:0]  w_byte;
   mem_wb_t     r_mw;

   assign w_half = ALUOutM[1] ? w_rword[31:16] : w_rword[15:0];
   assign w_byte = w_rword[{ALUOutM[1:0], 3'b000} +: 8];

   always_comb begin
      w_misalign = |ALUOutM[1:0];
      w_be       = 4'b1111;
      w_wdata    = WriteDataM;
      w_load     = w_rword;
      unique case (MemSizeM)
         SIZE_HALF: begin
            w_misalign = ALUOutM[0];
            w_be       = ALUOutM[1] ? 4'b1100 : 4'b0011;
            w_wdata    = {2{WriteDataM[15:0]}};
            w_load     = {{16{MemSignedM & w_half[15]}}, w_half};
         end
         SIZE_BYTE: begin
            w_misalign = 1'b0;
            w_be       = 4'b0001 << ALUOutM[1:0];
            w_wdata    = {4{WriteDataM[7:0]}};
            w_load     = {{24{MemSignedM & w_byte[7]}}, w_byte};
         end
         default: ;
      endcase
   end

   // stores never land while the W register is held, flushed or in reset
   assign w_we = MemWriteM & ~w_misalign & ~StallW & ~FlushW & ~rst;

   data_memory #(.DEPTH(DEPTH)) u_dmem (
      .clk     (clk),
      .i_we    (w_we),
      .i_addr  (ALUOutM[AW+1:2]),
      .i_be    (w_be),
      .i_wdata (w_wdata),
      .o_rdata (w_rword)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mw <= '0;
      end else if (FlushW) begin
         r_mw <= '0;
      end else if (!StallW) begin
         r_mw.reg_write  <= RegWriteM & ~w_misalign;
         r_mw.mem_to_reg <= MemToRegM;
         r_mw.alu_out    <= ALUOutM;
         r_mw.read_data  <= w_load;
         r_mw.write_reg  <= WriteRegM;
         r_mw.misalign   <= w_misalign;
      end
   end

   assign RegWriteW = r_mw.reg_write;
   assign MemToRegW = r_mw.mem_to_reg;
   assign ALUOutW   = r_mw.alu_out;
   assign ReadDataW = r_mw.read_data;
   assign WriteRegW = r_mw.write_reg;
   assign MisalignW = r_mw.misalign;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with hand-computed expectations.
module tb_memory_stage;
   import memory_stage_pkg::*;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        RegWriteM = 1'b0;
   logic        MemToRegM = 1'b0;
   logic        MemWriteM = 1'b0;
   logic [1:0]  MemSizeM = 2'b00;
   logic        MemSignedM = 1'b0;
   logic [31:0] ALUOutM = '0;
   logic [31:0] WriteDataM = '0;
   logic [4:0]  WriteRegM = '0;
   logic        StallW = 1'b0;
   logic        FlushW = 1'b0;
   logic        RegWriteW;
   logic        MemToRegW;
   logic [31:0] ALUOutW;
   logic [31:0] ReadDataW;
   logic [4:0]  WriteRegW;
   logic        MisalignW;

   int n_run  = 0;
   int n_fail = 0;

   logic [71:0] w_all;
   assign w_all = {RegWriteW, MemToRegW, ALUOutW, ReadDataW,
                   WriteRegW, MisalignW};

   always #5 clk = ~clk;

   memory_stage #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .RegWriteM  (RegWriteM),
      .MemToRegM  (MemToRegM),
      .MemWriteM  (MemWriteM),
      .MemSizeM   (MemSizeM),
      .MemSignedM (MemSignedM),
      .ALUOutM    (ALUOutM),
      .WriteDataM (WriteDataM),
      .WriteRegM  (WriteRegM),
      .StallW     (StallW),
      .FlushW     (FlushW),
      .RegWriteW  (RegWriteW),
      .MemToRegW  (MemToRegW),
      .ALUOutW    (ALUOutW),
      .ReadDataW  (ReadDataW),
      .WriteRegW  (WriteRegW),
      .MisalignW  (MisalignW)
   );

   task automatic chk(input string tag, input logic [71:0] got,
                      input logic [71:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drv(input logic rw, input logic m2r, input logic mw,
                      input logic [1:0] sz, input logic sgn,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [4:0] wr);
      RegWriteM  = rw;
      MemToRegM  = m2r;
      MemWriteM  = mw;
      MemSizeM   = sz;
      MemSignedM = sgn;
      ALUOutM    = a;
      WriteDataM = wd;
      WriteRegM  = wr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [1:0] sz, input logic sgn,
                       input logic [31:0] a);
      drv(1'b1, 1'b1, 1'b0, sz, sgn, a, 32'h0, 5'd3);
      step();
   endtask

   initial begin
      step();
      step();
      chk("reset_all", w_all, 72'h0);
      rst = 1'b0;

      drv(1'b0, 1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0);
      step();
      chk("sw_misalign", {71'h0, MisalignW}, 72'h0);

      load(SIZE_WORD, 1'b0, 32'h10);
      chk("lw_data", {40'h0, ReadDataW}, {40'h0, 32'hDEADBEEF});
      chk("lw_ctrl", {66'h0, RegWriteW, MemToRegW, WriteRegW[3:0]},
          {66'h0, 1'b1, 1'b1, 4'd3});
      chk("lw_alu", {40'h0, ALUOutW}, {40'h0, 32'h10});

      load(SIZE_BYTE, 1'b1, 32'h13);
      chk("lb_13", {40'h0, ReadDataW}, {40'h0, 32'hFFFFFFDE});
      load(SIZE_BYTE, 1'b0, 32'h13);
      chk("lbu_13", {40'h0, ReadDataW}, {40'h0, 32'h000000DE});
      load(SIZE_HALF, 1'b1, 32'h10);
      chk("lh_10", {40'h0, ReadDataW}, {40'h0, 32'hFFFFBEEF});
      load(SIZE_HALF, 1'b0, 32'h12);
      chk("lhu_12", {40'h0, ReadDataW}, {40'h0, 32'h0000DEAD});

      drv(1'b0, 1'b0, 1'b1, SIZE_BYTE, 1'b0, 32'h11, 32'hAAAA_AA55, 5'd0);
      step();
      load(SIZE_WORD, 1'b0, 32'h10);
      chk("sb_11", {40'h0, ReadDataW}, {40'h0, 32'hDEAD55EF});

      drv(1'b1, 1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h12, 32'h12345678, 5'd9);
      step();
      chk("sw_mis_flag", {70'h0, MisalignW, RegWriteW}, {70'h0, 2'b10});
      load(SIZE_WORD, 1'b0, 32'h10);
      chk("sw_mis_mem", {40'h0, ReadDataW}, {40'h0, 32'hDEAD55EF});

      load(SIZE_HALF, 1'b1, 32'h11);
      chk("lh_mis", {70'h0, MisalignW, RegWriteW}, {70'h0, 2'b10});

      drv(1'b0, 1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h10 + DEPTH * 4,
          32'hCAFEF00D, 5'd0);
      step();
      drv(1'b1, 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 5'd7);
      step();
      chk("wrap", {40'h0, ReadDataW}, {40'h0, 32'hCAFEF00D});

      StallW = 1'b1;
      drv(1'b0, 1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h10, 32'h0, 5'd2);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("stall_%0d", i), w_all,
             {1'b1, 1'b1, 32'h10, 32'hCAFEF00D, 5'd7, 1'b0});
      end
      StallW = 1'b0;
      drv(1'b1, 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 5'd7);
      step();
      chk("stall_nowr", {40'h0, ReadDataW}, {40'h0, 32'hCAFEF00D});

      StallW = 1'b1;
      FlushW = 1'b1;
      step();
      chk("flush", w_all, 72'h0);
      StallW = 1'b0;
      FlushW = 1'b0;

      load(SIZE_WORD, 1'b0, 32'h10);
      chk("pre_rst", {40'h0, ReadDataW}, {40'h0, 32'hCAFEF00D});
      #2 rst = 1'b1;
      #1 chk("rst_pulse", w_all, 72'h0);
      rst = 1'b0;
      step();
      chk("post_rst", {40'h0, ReadDataW}, {40'h0, 32'hCAFEF00D});

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 256, data-memory depth in 32-bit words (power of two).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port RegWriteM  input  1  instruction writes the register file.
REQ-005 SHALL have port MemToRegM  input  1  result selects load data over ALU result.
REQ-006 SHALL have port MemWriteM  input  1  store request.
REQ-007 SHALL have port MemSizeM  input  2  access size: 00 word, 01 half, 10 byte, 11 treated as word.
REQ-008 SHALL have port MemSignedM  input  1  sign-extend sub-word loads when 1, zero-extend when 0.
REQ-009 SHALL have port ALUOutM  input  32  byte address and pass-through ALU result.
REQ-010 SHALL have port WriteDataM  input  32  store data, taken from the low bytes for sub-word stores.
REQ-011 SHALL have port WriteRegM  input  5  destination register.
REQ-012 SHALL have port StallW  input  1  hold the MEM/WB register.
REQ-013 SHALL have port FlushW  input  1  load a bubble into the MEM/WB register.
REQ-014 SHALL have outputs RegWriteW (1), MemToRegW (1), ALUOutW (32), ReadDataW (32), WriteRegW (5) and MisalignW (1), all registered, consumed by the writeback stage.

Function
REQ-015 SHALL index memory with ALUOutM[log2(DEPTH)+1:2] and ignore higher address bits (wrap-around).
REQ-016 SHALL flag misalignment when the access is word and ALUOutM[1:0]!=0, or half and ALUOutM[0]!=0.
REQ-017 SHALL commit a store on the rising edge only when MemWriteM=1, not misaligned, StallW=0 and FlushW=0.
REQ-018 SHALL update only the addressed lanes on a store, little-endian: byte lane ALUOutM[1:0], half lane ALUOutM[1].
REQ-019 SHALL compute load data combinationally from the addressed word, then lane-select and extend per MemSizeM/MemSignedM.
REQ-020 SHALL register load data into ReadDataW with 1-cycle latency, M to W, and pass the control/ALUOut/WriteReg fields unchanged.
REQ-021 SHALL force RegWriteW=0 and MisalignW=1 in the W register for a misaligned access, whether load or store.
REQ-022 SHALL hold every W output while StallW=1 and FlushW=0.
REQ-023 SHALL clear every W output to 0 on FlushW=1 (a bubble); FlushW has priority over StallW.
REQ-024 SHALL, for a store followed by a load to the same word on the next cycle, return the newly written data (no read-during-write hazard across cycles).

Reset
REQ-025 SHALL clear every W output to 0 immediately on rst assertion, mid-operation included, and hold it while rst=1.
REQ-026 SHALL block stores while rst=1 and leave memory contents uninitialised by reset.

Structure
REQ-027 SHALL take the MemSizeM encodings (SIZE_WORD, SIZE_HALF, SIZE_BYTE) from the shared pipeline package used by all stages.
REQ-028 SHALL hold the storage array and lane-write logic in one sub-module, data_memory; the stage holds the alignment, extension and MEM/WB logic.

Verification
REQ-029 SHALL cover: store word 0xDEADBEEF at 0x10, then load word at 0x10 -> ReadDataW=0xDEADBEEF one cycle later.
REQ-030 SHALL cover: signed byte load at 0x13 -> 0xFFFFFFDE; unsigned byte load -> 0x000000DE; signed half load at 0x10 -> 0xFFFFBEEF.
REQ-031 SHALL cover: store byte 0x55 at 0x11, then load word at 0x10 -> 0xDEAD55EF.
REQ-032 SHALL cover: store word at 0x12 -> MisalignW=1, RegWriteW=0, and the word at 0x10 unchanged on reload.
REQ-033 SHALL cover: StallW=1 for 3 cycles holds all W outputs; FlushW=1 with StallW=1 -> all W outputs 0; rst pulse between edges -> W outputs 0 before the next edge.
